// File: rtl/life_engine.sv
// 8x8 Game-of-Life engine: quadrant-addressed board, one cell evaluated per clock
// into a shadow board that is committed in a single cycle.
module life_engine #(
   parameter int WRAP  = 1,
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_enb,
   input  logic [1:0]       pos,
   input  logic [15:0]      val,
   input  logic             step,
   input  logic [1:0]       rd_pos,
   output logic [15:0]      rd_val,
   output logic             busy,
   output logic             done,
   output logic [GEN_W-1:0] gen_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_COMMIT
   } state_t;

   state_t             r_state;
   logic [63:0]        r_cur;
   logic [63:0]        r_nxt;
   logic [5:0]         r_idx;
   logic               r_busy;
   logic               r_done;
   logic [GEN_W-1:0]   r_gen;

   logic [63:0]        w_cur_wr;
   logic [2:0]         w_row;
   logic [2:0]         w_col;
   logic [8:0]         w_nb;
   logic [3:0]         w_n;
   logic               w_next_cell;

   // Boards are stored flat as row*8+col; quadrant words are just a bit permutation of it.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_rd
         localparam logic [1:0] RR = 2'(gi % 4);
         localparam logic [1:0] CC = 2'(gi / 4);
         assign rd_val[gi] = r_cur[{rd_pos[0], RR, rd_pos[1], CC}];
      end

      for (gi = 0; gi < 64; gi++) begin : g_wr
         localparam int ROW = gi / 8;
         localparam int COL = gi % 8;
         localparam int QI  = 2 * (COL / 4) + (ROW / 4);
         localparam int BI  = 4 * (COL % 4) + (ROW % 4);
         assign w_cur_wr[gi] = (write_enb && (pos == 2'(QI))) ? val[BI] : r_cur[gi];
      end
   endgenerate

   assign w_row = r_idx[5:3];
   assign w_col = r_idx[2:0];

   // Neighbour k sits at offset (k/3-1, k%3-1); k==4 is the cell itself.
   generate
      for (gi = 0; gi < 9; gi++) begin : g_nb
         if (gi == 4) begin : g_self
            assign w_nb[gi] = 1'b0;
         end else begin : g_other
            localparam int DR = gi / 3 - 1;
            localparam int DC = gi % 3 - 1;
            logic [2:0] w_nr;
            logic [2:0] w_nc;
            logic       w_ok;
            assign w_nr = w_row + 3'(DR);
            assign w_nc = w_col + 3'(DC);
            assign w_ok = (WRAP != 0) ||
                          (!((DR == -1) && (w_row == 3'd0)) &&
                           !((DR ==  1) && (w_row == 3'd7)) &&
                           !((DC == -1) && (w_col == 3'd0)) &&
                           !((DC ==  1) && (w_col == 3'd7)));
            assign w_nb[gi] = w_ok && r_cur[{w_nr, w_nc}];
         end
      end
   endgenerate

   always_comb begin
      w_n = 4'd0;
      for (int k = 0; k < 9; k++) begin
         w_n = w_n + 4'(w_nb[k]);
      end
   end

   assign w_next_cell = (w_n == 4'd3) | (r_cur[r_idx] & (w_n == 4'd2));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_nxt   <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_gen   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A write in the same cycle as step lands first; evaluation starts next edge.
               r_cur <= w_cur_wr;
               if (step) begin
                  r_state <= S_COMPUTE;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_COMPUTE: begin
               r_nxt[r_idx] <= w_next_cell;
               r_idx        <= r_idx + 6'd1;
               if (r_idx == 6'd63) begin
                  r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               r_cur   <= r_nxt;
               r_gen   <= r_gen + 1'b1;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign gen_count = r_gen;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: a toroidal and a dead-edge instance share all inputs.
module tb_life_engine;

   typedef logic [3:0][15:0] board_t;   // [0]=TL [1]=BL [2]=TR [3]=BR
   typedef struct {
      board_t din;
      board_t exp_w;
      board_t exp_nw;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        write_enb;
   logic [1:0]  pos;
   logic [15:0] val;
   logic        step;
   logic [1:0]  rd_pos;
   logic [15:0] rd_val,  rd_val_nw;
   logic        busy,    busy_nw;
   logic        done,    done_nw;
   logic [15:0] gen_count, gen_count_nw;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] exp_gen;
   vec_t        vecs[7];

   always #5 clk = ~clk;

   life_engine #(.WRAP(1), .GEN_W(16)) dut (
      .clk(clk), .reset(reset), .write_enb(write_enb), .pos(pos), .val(val),
      .step(step), .rd_pos(rd_pos), .rd_val(rd_val), .busy(busy), .done(done),
      .gen_count(gen_count)
   );

   life_engine #(.WRAP(0), .GEN_W(16)) dut_nw (
      .clk(clk), .reset(reset), .write_enb(write_enb), .pos(pos), .val(val),
      .step(step), .rd_pos(rd_pos), .rd_val(rd_val_nw), .busy(busy_nw), .done(done_nw),
      .gen_count(gen_count_nw)
   );

   function automatic board_t mk(input logic [15:0] tl, input logic [15:0] bl,
                                 input logic [15:0] tr, input logic [15:0] br);
      board_t b;
      b[0] = tl; b[1] = bl; b[2] = tr; b[3] = br;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic write_quad(input logic [1:0] q, input logic [15:0] v);
      write_enb = 1'b1; pos = q; val = v;
      @(negedge clk);
      write_enb = 1'b0;
   endtask

   task automatic load(input board_t b);
      for (int q = 0; q < 4; q++) write_quad(2'(q), b[q]);
   endtask

   // Inspects the current negedge first; cnt0 = busy cycles already elapsed.
   task automatic wait_done(input string tag, input int cnt0);
      int cnt;
      bit seen;
      cnt  = cnt0;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) cnt++;
         @(negedge clk);
      end
      chk({tag, " done seen"}, 32'(seen), 32'd1);
      chk({tag, " busy cycles"}, cnt, 32'd65);
      chk({tag, " busy at done"}, 32'(busy), 32'd0);
      chk({tag, " nowrap done"}, 32'(done_nw), 32'd1);
      exp_gen = exp_gen + 16'd1;
      chk({tag, " gen_count"}, 32'(gen_count), 32'(exp_gen));
   endtask

   // Reads all quadrants within the current clock phase (4 x #1).
   task automatic check_board(input string tag, input board_t ew, input board_t enw);
      board_t got;
      for (int q = 0; q < 4; q++) begin
         rd_pos = 2'(q);
         #1;
         got[q] = rd_val;
         chk($sformatf("%s wrap q%0d", tag, q), 32'(rd_val), 32'(ew[q]));
         chk($sformatf("%s nowrap q%0d", tag, q), 32'(rd_val_nw), 32'(enw[q]));
      end
      $display("gen %0d %s: TL=%h BL=%h TR=%h BR=%h", gen_count, tag,
               got[0], got[1], got[2], got[3]);
   endtask

   task automatic run_and_check(input string tag, input board_t ew, input board_t enw);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_done(tag, 0);
      check_board(tag, ew, enw);
      @(negedge clk);
      chk({tag, " done width"}, 32'(done), 32'd0);
   endtask

   board_t b_h, b_v, b_zero;
   int     pulses, last_at;

   initial begin
      b_h    = mk(16'h8800, 16'h0000, 16'h0008, 16'h0000);
      b_v    = mk(16'hC000, 16'h1000, 16'h0000, 16'h0000);
      b_zero = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000);

      vecs[0] = '{mk(16'h8000, 16'h1000, 16'h0008, 16'h0001),
                  mk(16'h8000, 16'h1000, 16'h0008, 16'h0001),
                  mk(16'h8000, 16'h1000, 16'h0008, 16'h0001)};
      vecs[1] = '{b_h, b_v, b_v};
      vecs[2] = '{b_v, b_h, b_h};
      vecs[3] = '{mk(16'h0007, 16'h0000, 16'h0000, 16'h0000),
                  mk(16'h0022, 16'h0000, 16'h2000, 16'h0000),
                  mk(16'h0022, 16'h0000, 16'h0000, 16'h0000)};
      vecs[4] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                  b_zero,
                  mk(16'h0001, 16'h0008, 16'h1000, 16'h8000)};
      vecs[5] = '{mk(16'h0001, 16'h0008, 16'h1000, 16'h8000),
                  mk(16'h0001, 16'h0008, 16'h1000, 16'h8000),
                  b_zero};
      vecs[6] = '{mk(16'h0260, 16'h0000, 16'h0000, 16'h0000),
                  mk(16'h0660, 16'h0000, 16'h0000, 16'h0000),
                  mk(16'h0660, 16'h0000, 16'h0000, 16'h0000)};

      reset = 1'b1; write_enb = 1'b0; pos = 2'd0; val = 16'h0; step = 1'b0; rd_pos = 2'd0;
      exp_gen = 16'd0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset gen", 32'(gen_count), 32'd0);
      check_board("reset", b_zero, b_zero);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         load(vecs[v].din);
         run_and_check($sformatf("vec%0d", v), vecs[v].exp_w, vecs[v].exp_nw);
      end

      // Write/step collision: step arrives with the last quadrant write.
      write_quad(2'd0, 16'h8800);
      write_quad(2'd1, 16'h0000);
      write_quad(2'd3, 16'h0000);
      write_enb = 1'b1; pos = 2'd2; val = 16'h0008; step = 1'b1;
      @(negedge clk);
      write_enb = 1'b0; step = 1'b0;
      wait_done("collide", 0);
      check_board("collide", b_v, b_v);
      @(negedge clk);

      // Second step on the same board restores the horizontal blinker.
      run_and_check("blink2", b_h, b_h);

      // Write during COMPUTE is ignored; old generation stays visible.
      step = 1'b1;
      @(negedge clk);
      step = 1'b0; rd_pos = 2'd0;
      repeat (10) @(negedge clk);
      chk("mid busy", 32'(busy), 32'd1);
      chk("mid old TL", 32'(rd_val), 32'h8800);
      write_enb = 1'b1; pos = 2'd3; val = 16'hFFFF;
      @(negedge clk);
      write_enb = 1'b0;
      wait_done("busywr", 11);
      check_board("busywr", b_v, b_v);
      @(negedge clk);

      // Reset at cycle 30 of COMPUTE abandons the generation.
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_gen = 16'd0;
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid done", 32'(done), 32'd0);
      chk("rst mid gen", 32'(gen_count), 32'd0);
      chk("rst mid gen nowrap", 32'(gen_count_nw), 32'd0);
      check_board("rst mid", b_zero, b_zero);
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("rst no done", pulses, 32'd0);
      run_and_check("empty", b_zero, b_zero);

      // Held step: back-to-back generations every 66 cycles, busy writes dropped.
      load(b_h);
      rd_pos = 2'd0;
      step = 1'b1;
      pulses = 0; last_at = 0;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         write_enb = 1'b0;
         if (i == 20 || i == 100) begin
            write_enb = 1'b1; pos = 2'd0; val = 16'hFFFF;
         end
         if (done) begin
            pulses++;
            exp_gen = exp_gen + 16'd1;
            chk($sformatf("held pulse%0d at", pulses), i, 32'(66 * pulses));
            chk($sformatf("held pulse%0d TL", pulses), 32'(rd_val),
                (pulses % 2 == 1) ? 32'hC000 : 32'h8800);
            chk($sformatf("held pulse%0d gen", pulses), 32'(gen_count), 32'(exp_gen));
            $display("held pulse %0d at cycle %0d TL=%h", pulses, i, rd_val);
            last_at = i;
         end
      end
      chk("held pulses", pulses, 32'd3);
      @(negedge clk);
      step = 1'b0;
      wait_done("held tail", 1);
      check_board("held tail", b_h, b_h);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
